mem_port_arbiter: RTL and testbench

//  Shares one unified memory port between the IF-stage fetch requester and the MA-stage data requester.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one busywait-style memory port between IF fetch and MA data requesters
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie-break instead of fixed MA priority + starvation guard)
module mem_port_arbiter #(
  parameter int         ADDR_WIDTH   = 32,
  parameter int         DATA_WIDTH   = 32,
  parameter logic [3:0] IF_READ_CODE = 4'b1010,
  parameter int         STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_read,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_busywait,
  input  logic [3:0]            ma_read,
  input  logic [2:0]            ma_write,
  input  logic [ADDR_WIDTH-1:0] ma_addr,
  input  logic [DATA_WIDTH-1:0] ma_wdata,
  output logic [DATA_WIDTH-1:0] ma_rdata,
  output logic                  ma_busywait,
  output logic [3:0]            mem_read,
  output logic [2:0]            mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_busywait
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GRANT_IF = 3'd1;
  localparam logic [2:0] GRANT_MA = 3'd2;
  localparam logic [2:0] RESP_IF  = 3'd3;
  localparam logic [2:0] RESP_MA  = 3'd4;

  logic [2:0] state;
  logic       if_req;
  logic       ma_req;
  logic       pick_if;
  logic       first_cycle;
  logic       grant_done;
  logic       start;

  assign if_req      = if_read;
  assign ma_req      = ma_read[3] | ma_write[2];
  assign if_busywait = if_req & (state != RESP_IF);
  assign ma_busywait = ma_req & (state != RESP_MA);
  assign start       = (state == IDLE) & (if_req | ma_req);
  // Memory busywait is not yet meaningful in the first grant cycle.
  assign grant_done  = ~first_cycle & ~mem_busywait;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_if;

  assign pick_if = if_req & (~ma_req | ~last_grant_if);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_if <= 1'b1;
    end else if (start) begin
      last_grant_if <= pick_if;
    end
  end
`else
  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign pick_if = if_req & (~ma_req | (starve_cnt == LIMIT_C));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (start) begin
      if (pick_if) begin
        starve_cnt <= '0;
      end else if (if_req && (starve_cnt != LIMIT_C)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      first_cycle <= 1'b0;
      mem_read    <= '0;
      mem_write   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      ma_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            first_cycle <= 1'b1;
            if (pick_if) begin
              state     <= GRANT_IF;
              mem_read  <= IF_READ_CODE;
              mem_write <= '0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
            end else begin
              state     <= GRANT_MA;
              // A load+store collision is executed as the store alone.
              mem_read  <= (ma_read[3] & ma_write[2]) ? 4'b0000 : ma_read;
              mem_write <= ma_write;
              mem_addr  <= ma_addr;
              mem_wdata <= ma_wdata;
            end
          end
        end
        GRANT_IF: begin
          first_cycle <= 1'b0;
          if (grant_done) begin
            state     <= RESP_IF;
            mem_read  <= '0;
            mem_write <= '0;
            if_rdata  <= mem_rdata;
          end
        end
        GRANT_MA: begin
          first_cycle <= 1'b0;
          if (grant_done) begin
            state     <= RESP_MA;
            mem_read  <= '0;
            mem_write <= '0;
            if (mem_read[3]) begin
              ma_rdata <= mem_rdata;
            end
          end
        end
        RESP_IF, RESP_MA: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Honours ARB_ROUND_ROBIN_EN when defined for the build.
module tb_mem_port_arbiter;

  localparam logic [3:0] IF_CODE = 4'b1010;
  localparam int         LIMIT   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_read;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_busywait;
  logic [3:0]  ma_read;
  logic [2:0]  ma_write;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic [31:0] ma_rdata;
  logic        ma_busywait;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_busywait;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: transaction-level view of the arbiter.
  int          m_starve;
  bit          m_last_if;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_ma_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_read(if_read), .if_addr(if_addr), .if_rdata(if_rdata), .if_busywait(if_busywait),
    .ma_read(ma_read), .ma_write(ma_write), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
    .ma_rdata(ma_rdata), .ma_busywait(ma_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_busywait(mem_busywait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve     = 0;
    m_last_if    = 1'b1;
    exp_if_rdata = '0;
    exp_ma_rdata = '0;
  endtask

  function automatic bit model_pick_if(input bit ifr, input bit mar);
    if (!mar) return 1'b1;
    if (!ifr) return 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    return !m_last_if;
`else
    return m_starve == LIMIT;
`endif
  endfunction

  task automatic model_grant(input bit ifr, input bit wif);
    m_last_if = wif;
    if (wif) m_starve = 0;
    else if (ifr && m_starve < LIMIT) m_starve = m_starve + 1;
  endtask

  // One complete access, started in an IDLE cycle. Latency from request to
  // the winner's busywait going low is 3 + busy cycles.
  task automatic run_txn(input bit ifr, input logic [31:0] ia, input logic [3:0] mr,
                         input logic [2:0] mw, input logic [31:0] maa, input logic [31:0] mwd,
                         input logic [31:0] rd, input int busy, input int drop_cyc,
                         output bit won_if);
    bit          mar, wif, still, los_req, is_load;
    int          lat;
    logic [3:0]  e_rd;
    logic [2:0]  e_wr;
    logic [31:0] e_addr;
    mar = mr[3] | mw[2];
    wif = model_pick_if(ifr, mar);
    model_grant(ifr, wif);
    if (wif) begin
      e_rd = IF_CODE; e_wr = 3'b000; e_addr = ia;
    end else begin
      e_rd = (mr[3] & mw[2]) ? 4'b0000 : mr; e_wr = mw; e_addr = maa;
    end
    is_load = wif ? 1'b1 : e_rd[3];
    los_req = wif ? mar : ifr;
    lat     = 3 + busy;
    still   = 1'b1;
    won_if  = 1'b0;

    if_read = ifr; if_addr = ia; ma_read = mr; ma_write = mw; ma_addr = maa; ma_wdata = mwd;
    mem_busywait = 1'b1; mem_rdata = ~rd;
    @(negedge clk);
    check("idle_if_bw", 32'(if_busywait), 32'(ifr));
    check("idle_ma_bw", 32'(ma_busywait), 32'(mar));
    check("idle_mem_read", 32'(mem_read), 32'h0);

    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        mem_busywait = 1'($urandom_range(0, 1));
        if_addr  = $urandom;
        ma_addr  = $urandom;
        ma_wdata = $urandom;
      end else begin
        mem_busywait = (c >= 2 + busy && c < lat) ? 1'b0 : 1'b1;
      end
      mem_rdata = (c >= 2 + busy && c < lat) ? rd : ~rd;
      if (c == drop_cyc) begin
        if (wif) if_read = 1'b0;
        else begin ma_read = 4'b0000; ma_write = 3'b000; end
        still = 1'b0;
      end
      if (c == lat && is_load) begin
        if (wif) exp_if_rdata = rd;
        else     exp_ma_rdata = rd;
      end
      @(negedge clk);
      if (wif) begin
        check("win_if_bw", 32'(if_busywait), 32'(still && c != lat));
        check("los_ma_bw", 32'(ma_busywait), 32'(los_req));
      end else begin
        check("win_ma_bw", 32'(ma_busywait), 32'(still && c != lat));
        check("los_if_bw", 32'(if_busywait), 32'(los_req));
      end
      check("mem_read", 32'(mem_read), (c < lat) ? 32'(e_rd) : 32'h0);
      check("mem_write", 32'(mem_write), (c < lat) ? 32'(e_wr) : 32'h0);
      if (c < lat) check("mem_addr", mem_addr, e_addr);
      if (c < lat && !wif) check("mem_wdata", mem_wdata, mwd);
      check("if_rdata", if_rdata, exp_if_rdata);
      check("ma_rdata", ma_rdata, exp_ma_rdata);
      if (c == lat) won_if = ifr && still && !if_busywait;
    end
    @(posedge clk); #1;
    mem_busywait = 1'b1;
  endtask

  initial begin
    bit          won;
    bit          exp_order [6];
    int          kind, busy, drop;
    bit          ifr;
    logic [3:0]  mr;
    logic [2:0]  mw;

`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif

    rst_n = 1'b0; if_read = 1'b0; if_addr = '0; ma_read = '0; ma_write = '0;
    ma_addr = '0; ma_wdata = '0; mem_rdata = '0; mem_busywait = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_ma_rdata", ma_rdata, 32'h0);
    check("rst_if_bw", 32'(if_busywait), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Zero-wait MA load: busywait low 3 cycles after request, MEM_READ for 2 cycles.
    run_txn(1'b0, 32'h0, 4'b1010, 3'b000, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 0, 0, won);
    // IF-only fetch with two busy cycles after grant.
    run_txn(1'b1, 32'h0000_0100, 4'b0000, 3'b000, 32'h0, 32'h0, 32'h0050_0093, 2, 0, won);

    // Reset while a load is in its first grant cycle.
    ma_read = 4'b1010; ma_write = 3'b000; ma_addr = 32'h40; ma_wdata = 32'h1234;
    mem_busywait = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_mem_read", 32'(mem_read), 32'hA);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_mem_read", 32'(mem_read), 32'h0);
    check("midrst_mem_write", 32'(mem_write), 32'h0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    check("midrst_mem_wdata", mem_wdata, 32'h0);
    check("midrst_if_rdata", if_rdata, 32'h0);
    check("midrst_ma_rdata", ma_rdata, 32'h0);
    ma_read = 4'b0000;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // MA store: codes and data reach memory, MA_RDATA stays put.
    run_txn(1'b0, 32'h0, 4'b0000, 3'b110, 32'h0000_0010, 32'hDEAD_BEEF, 32'h7777_7777, 1, 0, won);

    // Both requesters held: grant order from the arbitration rule.
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b1, 32'h200 + 32'(i * 4), 4'b1100, 3'b000, 32'h300 + 32'(i * 4), 32'h0,
              $urandom, 0, 0, won);
      check("tie_order", 32'(won), 32'(exp_order[i]));
    end

    // IF withdraws in the second grant cycle; the latched fetch still completes.
    run_txn(1'b1, 32'h0000_0400, 4'b0000, 3'b000, 32'h0, 32'h0, 32'h1357_9BDF, 1, 2, won);

    // Illegal load+store collision behaves as a store.
    run_txn(1'b0, 32'h0, 4'b1010, 3'b101, 32'h0000_0044, 32'hA5A5_5A5A, 32'h2468_ACE0, 0, 0, won);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      ifr  = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 3);
      if (!ifr && kind == 0) kind = 1;
      case (kind)
        1:       begin mr = {1'b1, 3'($urandom)}; mw = {1'b0, 2'($urandom)}; end
        2:       begin mr = {1'b0, 3'($urandom)}; mw = {1'b1, 2'($urandom)}; end
        3:       begin mr = {1'b1, 3'($urandom)}; mw = {1'b1, 2'($urandom)}; end
        default: begin mr = {1'b0, 3'($urandom)}; mw = {1'b0, 2'($urandom)}; end
      endcase
      busy = $urandom_range(0, 3);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 + busy) : 0;
      run_txn(ifr, $urandom, mr, mw, $urandom, $urandom, $urandom, busy, drop, won);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
